// File: rtl/rvx10_pipe_pkg.sv
// Shared types and constants for the RV32/RVX10 pipeline hazard controller.
// Holds the hazard FSM state encoding and the default multi-cycle timeout.
// No logic; imported by pipe_hazard_ctrl and pipe_perf_cnt.
package rvx10_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MC_BUSY  = 2'd2
  } hz_state_t;

  // Default cycle budget for a multi-cycle RVX10 op before it is abandoned.
  localparam int unsigned MC_TIMEOUT_DEF = 64;

  // Timeout counter width; covers the full MC_TIMEOUT range of 2..255.
  localparam int unsigned TO_CNT_W = 8;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter for hazard-controller performance monitoring.
// Count updates one cycle after inc is sampled; sticks at all-ones.
// No backpressure; synchronous active-high reset clears to zero.
module pipe_perf_cnt
  import rvx10_pipe_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: advance on inc unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, taken branch, RVX10 multi-cycle hold.
// Stall/flush outputs are combinational (zero latency); State and McErr are registered.
// Optional PERF_CNT_EN macro adds StallCnt/FlushCnt/McCycCnt saturating counters.
module pipe_hazard_ctrl
  import rvx10_pipe_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = MC_TIMEOUT_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             ValidE,
  input  logic             PCSrcE,
  input  logic             McStartE,
  input  logic             McDone,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             StallE,
  output logic             McErr,
  output logic [1:0]       State
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] McCycCnt
`endif
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(MC_TIMEOUT - 1);

  hz_state_t           state_q, state_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                mc_err_q, mc_err_d;
  logic                load_use;
  logic                stall_f, stall_d, flush_d, flush_e, stall_e;

  // A load in EX whose destination (never x0) feeds a source of the ID instruction.
  assign load_use = ValidE & ResultSrcE0 & (RdE != 5'd0) &
                    ((RdE == Rs1D) | (RdE == Rs2D));

  // Hazard decode and next-state: branch beats multi-cycle start beats load-use.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    mc_err_d = mc_err_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    stall_e  = 1'b0;
    case (state_q)
      MC_BUSY: begin
        // EX owns the multi-cycle op; branches resolved there are not real yet.
        if (McDone) begin
          state_d  = RUN;
          to_cnt_d = '0;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          if (to_cnt_q == TO_LAST) begin
            mc_err_d = 1'b1;
            state_d  = RUN;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TO_CNT_W'(1);
          end
        end
      end
      default: begin
        // RUN and LD_STALL share rules; after a load-use bubble EX is normally idle.
        state_d  = RUN;
        to_cnt_d = '0;
        if (ValidE && PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (ValidE && McStartE) begin
          if (!McDone) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            state_d = MC_BUSY;
          end
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          state_d = LD_STALL;
        end
      end
    endcase
  end

  // Outputs are silenced while reset is held so nothing stalls during reset.
  assign StallF = stall_f & ~reset;
  assign StallD = stall_d & ~reset;
  assign FlushD = flush_d & ~reset;
  assign FlushE = flush_e & ~reset;
  assign StallE = stall_e & ~reset;
  assign McErr  = mc_err_q;
  assign State  = state_q;

  // FSM, timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      to_cnt_q <= '0;
      mc_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      mc_err_q <= mc_err_d;
    end
  end

`ifdef PERF_CNT_EN
  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .cnt   (StallCnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (FlushE),
    .cnt   (FlushCnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_mc_cyc_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state_q == MC_BUSY),
    .cnt   (McCycCnt)
  );
`else
  // Keeps CNT_W referenced in the counter-less build.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
